// File: rtl/bus_xfer_ctrl_if.sv
// ---------------------------------------------------------------------------
// bus_xfer_ctrl_if
//   Groups the signals of the bus transfer controller: the command handshake
//   from upstream, the req/gnt/done/dly link to the bus grant arbiter, and the
//   data-phase signals toward the bus slave.
//
//   Parameter
//     LEN_W      width of the burst length / beat index fields
//   Signals
//     cmd_valid, cmd_len, cmd_wr, cmd_ready   burst command handshake
//     req, gnt, done, dly                     arbiter link
//     bus_act, bus_wr, bus_ack, bus_last,
//     beat_cnt                                data phase
//     err                                     sticky protocol error
//   Modports
//     master   the controller side (drives req/done/dly and the data phase)
//     slave    the surroundings (command source, arbiter, bus slave)
// ---------------------------------------------------------------------------
interface bus_xfer_ctrl_if #(
  parameter int LEN_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_wr;
  logic             req;
  logic             gnt;
  logic             done;
  logic             dly;
  logic             bus_act;
  logic             bus_wr;
  logic             bus_ack;
  logic             bus_last;
  logic [LEN_W-1:0] beat_cnt;
  logic             err;

  modport master (
    input  cmd_valid, cmd_len, cmd_wr, gnt, bus_ack,
    output cmd_ready, req, done, dly, bus_act, bus_wr, bus_last, beat_cnt, err
  );

  modport slave (
    output cmd_valid, cmd_len, cmd_wr, gnt, bus_ack,
    input  cmd_ready, req, done, dly, bus_act, bus_wr, bus_last, beat_cnt, err
  );
endinterface

// File: rtl/bus_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// bus_xfer_ctrl
//   Bus-master transfer controller in front of the bus grant arbiter. Takes
//   one burst command at a time, requests the bus, runs the burst once the
//   grant arrives, pulses done, and for writes holds dly for RECOV cycles
//   (counting the done cycle) so the arbiter keeps the grant through the
//   post-write recovery window.
//
//   Parameters
//     LEN_W   burst length field width (max burst 2**LEN_W beats)
//     RECOV   post-write recovery cycles, 0..15 (0 = no recovery)
//   Ports
//     clk     rising-edge clock
//     rst     synchronous active-high reset
//     bus     bus_xfer_ctrl_if.master (command, arbiter and data-phase signals)
//
//   Every output is a decode of registered state: there is no combinational
//   path from gnt or bus_ack to any output.
// ---------------------------------------------------------------------------
module bus_xfer_ctrl #(
  parameter int LEN_W = 4,
  parameter int RECOV = 2
) (
  input  logic             clk,
  input  logic             rst,
  bus_xfer_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_XFER  = 3'd2,
    S_DONE  = 3'd3,
    S_RECOV = 3'd4
  } state_t;

  localparam int RC_W = 4;
  // dly is asserted in the done cycle whenever recovery is enabled at all;
  // the separate RECOV state is only needed for two or more dly cycles.
  localparam bit DLY_IN_DONE = (RECOV > 0);
  localparam bit RECOV_STATE = (RECOV > 1);
  localparam logic [RC_W-1:0] RECOV_LOAD = RC_W'((RECOV > 1) ? (RECOV - 1) : 1);

  state_t           state_reg,  state_next;
  logic [LEN_W-1:0] len_reg,    len_next;
  logic             wr_reg,     wr_next;
  logic [LEN_W-1:0] beat_reg,   beat_next;
  logic [RC_W-1:0]  rcnt_reg,   rcnt_next;
  logic             err_reg,    err_next;

  // Final-beat compare built bitwise so it depends only on registers.
  logic [LEN_W-1:0] beat_match;
  logic             last_beat;

  genvar gi;
  generate
    for (gi = 0; gi < LEN_W; gi++) begin : g_match
      assign beat_match[gi] = (beat_reg[gi] ~^ len_reg[gi]);
    end
  endgenerate

  assign last_beat = &beat_match;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      len_reg   <= '0;
      wr_reg    <= 1'b0;
      beat_reg  <= '0;
      rcnt_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      wr_reg    <= wr_next;
      beat_reg  <= beat_next;
      rcnt_reg  <= rcnt_next;
      err_reg   <= err_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    wr_next    = wr_reg;
    beat_next  = beat_reg;
    rcnt_next  = rcnt_reg;
    err_next   = err_reg;

    case (state_reg)
      S_IDLE: begin
        if (bus.cmd_valid && !err_reg) begin
          len_next   = bus.cmd_len;
          wr_next    = bus.cmd_wr;
          beat_next  = '0;
          state_next = S_REQ;
        end
      end

      S_REQ: begin
        if (bus.gnt) begin
          state_next = S_XFER;
        end
      end

      S_XFER: begin
        // A lost grant takes priority over a completing beat.
        if (!bus.gnt) begin
          err_next   = 1'b1;
          state_next = S_IDLE;
        end else if (bus.bus_ack) begin
          if (last_beat) begin
            // beat_cnt stays on the final index, so a full-length burst
            // ends at all-ones instead of wrapping.
            state_next = S_DONE;
          end else begin
            beat_next = beat_reg + LEN_W'(1);
          end
        end
      end

      S_DONE: begin
        if (!bus.gnt) begin
          err_next   = 1'b1;
          state_next = S_IDLE;
        end else if (wr_reg && RECOV_STATE) begin
          rcnt_next  = RECOV_LOAD;
          state_next = S_RECOV;
        end else begin
          state_next = S_IDLE;
        end
      end

      S_RECOV: begin
        // rcnt_reg counts the dly cycles still owed including this one.
        if (!bus.gnt) begin
          err_next   = 1'b1;
          state_next = S_IDLE;
        end else begin
          rcnt_next = rcnt_reg - RC_W'(1);
          if (rcnt_reg == RC_W'(1)) begin
            state_next = S_IDLE;
          end
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Moore output decodes
  assign bus.cmd_ready = (state_reg == S_IDLE) && !err_reg;
  assign bus.req       = (state_reg == S_REQ);
  assign bus.done      = (state_reg == S_DONE);
  assign bus.dly       = ((state_reg == S_DONE) && wr_reg && DLY_IN_DONE) ||
                         (state_reg == S_RECOV);
  assign bus.bus_act   = (state_reg == S_XFER);
  // Direction is only presented while the data phase is active.
  assign bus.bus_wr    = (state_reg == S_XFER) && wr_reg;
  assign bus.bus_last  = (state_reg == S_XFER) && last_beat;
  assign bus.beat_cnt  = beat_reg;
  assign bus.err       = err_reg;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bus_xfer_ctrl
//   Bench for bus_xfer_ctrl with a small arbiter model closing the req/gnt
//   loop, a transaction-level reference model compared every cycle, and
//   directed scenarios with literal per-cycle expectations.
// ---------------------------------------------------------------------------
module tb_bus_xfer_ctrl;

  localparam int LEN_W = 4;
  localparam int RECOV = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bus_xfer_ctrl_if #(.LEN_W(LEN_W)) bus ();

  bus_xfer_ctrl #(.LEN_W(LEN_W), .RECOV(RECOV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- arbiter model: free -> busy -> (wait) -> free ----------
  int   arb_st    = 0;   // 0 free, 1 busy, 2 waiting for dly to fall
  int   arb_wait  = 0;
  int   arb_delay = 0;   // extra cycles before a grant is issued
  logic arb_gnt   = 1'b0;
  logic gnt_kill  = 1'b0;

  assign bus.gnt = arb_gnt & ~gnt_kill;

  always @(posedge clk) begin
    if (rst) begin
      arb_st   <= 0;
      arb_wait <= 0;
      arb_gnt  <= 1'b0;
    end else begin
      case (arb_st)
        0: if (bus.req) begin
             if (arb_wait >= arb_delay) begin
               arb_st   <= 1;
               arb_gnt  <= 1'b1;
               arb_wait <= 0;
             end else begin
               arb_wait <= arb_wait + 1;
             end
           end
        1: if (bus.done) begin
             if (bus.dly) arb_st <= 2;
             else begin arb_st <= 0; arb_gnt <= 1'b0; end
           end
        default: if (!bus.dly) begin arb_st <= 0; arb_gnt <= 1'b0; end
      endcase
    end
  end

  // ---------------- reference model (transaction level) --------------------
  // One pending command; progress tracked as "granted", "all beats acked"
  // and a position inside the done/recovery tail.
  bit               m_ok   = 0;
  bit               m_pend = 0;
  bit               m_gr   = 0;
  bit               m_fin  = 0;
  bit               m_err  = 0;
  bit               m_wr   = 0;
  int               m_pos  = 0;
  logic [LEN_W-1:0] m_len  = '0;
  logic [LEN_W-1:0] m_cnt  = '0;

  function automatic int tail_len(input bit wr);
    return (wr && RECOV > 1) ? RECOV : 1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ok = 1; m_pend = 0; m_gr = 0; m_fin = 0; m_err = 0;
      m_wr = 0; m_pos = 0; m_len = '0; m_cnt = '0;
    end else if (m_ok) begin
      if (!m_pend) begin
        if (bus.cmd_valid && !m_err) begin
          m_pend = 1; m_gr = 0; m_fin = 0; m_pos = 0;
          m_len = bus.cmd_len; m_wr = bus.cmd_wr; m_cnt = '0;
        end
      end else if (!m_gr) begin
        if (bus.gnt) m_gr = 1;
      end else if (!bus.gnt) begin
        m_err = 1; m_pend = 0;
      end else if (!m_fin) begin
        if (bus.bus_ack) begin
          if (m_cnt == m_len) m_fin = 1;
          else m_cnt = m_cnt + 1'b1;
        end
      end else begin
        m_pos = m_pos + 1;
        if (m_pos >= tail_len(m_wr)) m_pend = 0;
      end
    end
  end

  function automatic logic [11:0] dut_vec();
    return {bus.req, bus.bus_act, bus.bus_last, bus.done, bus.dly,
            bus.cmd_ready, bus.err, bus.bus_wr, bus.beat_cnt};
  endfunction

  function automatic logic [11:0] model_vec();
    logic e_act;
    e_act = m_pend && m_gr && !m_fin;
    return {m_pend && !m_gr,
            e_act,
            e_act && (m_cnt == m_len),
            m_pend && m_fin && (m_pos == 0),
            m_pend && m_fin && m_wr && (RECOV > 0) && (m_pos < RECOV),
            !m_pend && !m_err,
            m_err,
            e_act && m_wr,
            m_cnt};
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle compare on the falling edge.
  always @(negedge clk) begin
    if (m_ok) begin
      logic [11:0] got;
      logic [11:0] exp;
      got = dut_vec();
      exp = model_vec();
      n_vec++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL model cycle %0d: dut {req,act,last,done,dly,rdy,err,wr,cnt}=%b model=%b",
                 cyc, got, exp);
      end
    end
  end

  // ---------------- directed stimulus helpers ------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [6:0] outs7();
    return {bus.req, bus.bus_act, bus.bus_last, bus.done, bus.dly, bus.cmd_ready, bus.err};
  endfunction

  // Check {req,act,last,done,dly,ready,err} for this cycle, drive bus_ack
  // for this cycle, then advance one clock.
  task automatic cyc_chk(input string name, input int k, input logic [6:0] exp,
                         input logic ack);
    chk($sformatf("%s k%0d", name, k), {5'b0, outs7()}, {5'b0, exp});
    bus.bus_ack = ack;
    tick();
  endtask

  task automatic start_cmd(input string name, input logic [LEN_W-1:0] len, input logic wr);
    chk($sformatf("%s ready k0", name), {11'b0, bus.cmd_ready}, 12'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = len;
    bus.cmd_wr    = wr;
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.cmd_wr    = 1'b0;
  endtask

  task automatic chk_cnt(input string name, input logic [LEN_W-1:0] exp);
    chk(name, {8'b0, bus.beat_cnt}, {8'b0, exp});
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.cmd_wr    = 1'b0;
    bus.bus_ack   = 1'b0;

    // Reset
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("reset state", dut_vec(), {7'b0000010, 1'b0, 4'h0});
    tick();

    // 1: read len=3, ack tied high
    start_cmd("rd3", 4'd3, 1'b0);
    cyc_chk("rd3", 1, 7'b1000000, 1);
    cyc_chk("rd3", 2, 7'b1000000, 1);
    cyc_chk("rd3", 3, 7'b0100000, 1);
    cyc_chk("rd3", 4, 7'b0100000, 1);
    cyc_chk("rd3", 5, 7'b0100000, 1);
    cyc_chk("rd3", 6, 7'b0110000, 1);
    chk_cnt("rd3 cnt at done", 4'd3);
    cyc_chk("rd3", 7, 7'b0001000, 0);
    cyc_chk("rd3", 8, 7'b0000010, 0);

    // 2: write len=0 with two recovery cycles
    start_cmd("wr0", 4'd0, 1'b1);
    cyc_chk("wr0", 1, 7'b1000000, 1);
    cyc_chk("wr0", 2, 7'b1000000, 1);
    chk("wr0 bus_wr k3", {11'b0, bus.bus_wr}, 12'd1);
    cyc_chk("wr0", 3, 7'b0110000, 1);
    cyc_chk("wr0", 4, 7'b0001100, 0);
    cyc_chk("wr0", 5, 7'b0000100, 0);
    chk("wr0 gnt held k6", {11'b0, bus.gnt}, 12'd1);
    cyc_chk("wr0", 6, 7'b0000010, 0);
    chk("wr0 gnt low k7", {11'b0, bus.gnt}, 12'd0);

    // 3: write len=1 with ack pattern 1,0,0,1
    start_cmd("wr1", 4'd1, 1'b1);
    cyc_chk("wr1", 1, 7'b1000000, 0);
    cyc_chk("wr1", 2, 7'b1000000, 0);
    chk_cnt("wr1 cnt k3", 4'd0);
    cyc_chk("wr1", 3, 7'b0100000, 1);
    chk_cnt("wr1 cnt k4", 4'd1);
    cyc_chk("wr1", 4, 7'b0110000, 0);
    chk_cnt("wr1 cnt k5", 4'd1);
    cyc_chk("wr1", 5, 7'b0110000, 0);
    cyc_chk("wr1", 6, 7'b0110000, 1);
    cyc_chk("wr1", 7, 7'b0001100, 0);
    cyc_chk("wr1", 8, 7'b0000100, 0);
    cyc_chk("wr1", 9, 7'b0000010, 0);

    // 4: grant delayed, cmd_valid toggling meanwhile must be ignored
    arb_delay = 5;
    start_cmd("dly", 4'd0, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      bus.cmd_valid = k[0];
      bus.cmd_len   = 4'(k + 5);
      bus.cmd_wr    = k[1];
      cyc_chk("gdly", k, 7'b1000000, 1);
    end
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.cmd_wr    = 1'b0;
    arb_delay     = 0;
    cyc_chk("gdly", 8, 7'b0110000, 1);
    cyc_chk("gdly", 9, 7'b0001000, 0);
    cyc_chk("gdly", 10, 7'b0000010, 0);

    // 5: grant lost mid-burst -> sticky err until reset
    start_cmd("gl", 4'd3, 1'b0);
    cyc_chk("gl", 1, 7'b1000000, 0);
    cyc_chk("gl", 2, 7'b1000000, 0);
    cyc_chk("gl", 3, 7'b0100000, 0);
    gnt_kill = 1'b1;
    cyc_chk("gl", 4, 7'b0100000, 0);
    gnt_kill = 1'b0;
    bus.cmd_valid = 1'b1;
    for (int k = 5; k <= 8; k++) cyc_chk("gl", k, 7'b0000001, 0);
    bus.cmd_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("gl after rst", {5'b0, outs7()}, {5'b0, 7'b0000010});
    tick();

    // 6: reset during recovery, then a normal read
    start_cmd("rr", 4'd0, 1'b1);
    cyc_chk("rr", 1, 7'b1000000, 1);
    cyc_chk("rr", 2, 7'b1000000, 1);
    cyc_chk("rr", 3, 7'b0110000, 1);
    cyc_chk("rr", 4, 7'b0001100, 0);
    chk("rr k5", {5'b0, outs7()}, {5'b0, 7'b0000100});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rr after rst", dut_vec(), {7'b0000010, 1'b0, 4'h0});
    tick();
    start_cmd("rr2", 4'd1, 1'b0);
    cyc_chk("rr2", 1, 7'b1000000, 1);
    cyc_chk("rr2", 2, 7'b1000000, 1);
    cyc_chk("rr2", 3, 7'b0100000, 1);
    cyc_chk("rr2", 4, 7'b0110000, 1);
    cyc_chk("rr2", 5, 7'b0001000, 0);
    cyc_chk("rr2", 6, 7'b0000010, 0);

    // 7: full-length burst ends on all-ones without wrapping
    start_cmd("max", 4'd15, 1'b0);
    for (int k = 1; k <= 18; k++) begin
      logic [6:0] e;
      if (k <= 2)       e = 7'b1000000;
      else if (k < 18)  e = 7'b0100000;
      else              e = 7'b0110000;
      cyc_chk("max", k, e, 1);
    end
    chk_cnt("max cnt at done", 4'd15);
    cyc_chk("max", 19, 7'b0001000, 0);
    cyc_chk("max", 20, 7'b0000010, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
